// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcode map, flag bit positions,
// sequencer states and opcode classification helpers.
package alu_pkg;

  localparam int ALU_WIDTH = 32;
  localparam int ALU_OPW   = 5;

  localparam logic [ALU_OPW-1:0] OP_AND   = 5'b00000;
  localparam logic [ALU_OPW-1:0] OP_EOR   = 5'b00001;
  localparam logic [ALU_OPW-1:0] OP_SUB   = 5'b00010;
  localparam logic [ALU_OPW-1:0] OP_RSB   = 5'b00011;
  localparam logic [ALU_OPW-1:0] OP_ADD   = 5'b00100;
  localparam logic [ALU_OPW-1:0] OP_ADC   = 5'b00101;
  localparam logic [ALU_OPW-1:0] OP_SBC   = 5'b00110;
  localparam logic [ALU_OPW-1:0] OP_RSC   = 5'b00111;
  localparam logic [ALU_OPW-1:0] OP_TST   = 5'b01000;
  localparam logic [ALU_OPW-1:0] OP_TEQ   = 5'b01001;
  localparam logic [ALU_OPW-1:0] OP_CMP   = 5'b01010;
  localparam logic [ALU_OPW-1:0] OP_CMN   = 5'b01011;
  localparam logic [ALU_OPW-1:0] OP_ORR   = 5'b01100;
  localparam logic [ALU_OPW-1:0] OP_MOV   = 5'b01101;
  localparam logic [ALU_OPW-1:0] OP_BIC   = 5'b01110;
  localparam logic [ALU_OPW-1:0] OP_MVN   = 5'b01111;
  localparam logic [ALU_OPW-1:0] OP_PASSA = 5'b10000;
  localparam logic [ALU_OPW-1:0] OP_INC4  = 5'b10001;
  localparam logic [ALU_OPW-1:0] OP_ADD4  = 5'b10010;
  localparam logic [ALU_OPW-1:0] OP_INCA  = 5'b11110;
  localparam logic [ALU_OPW-1:0] OP_INCB  = 5'b11111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic is_legal_op(input logic [ALU_OPW-1:0] op);
    return (op <= OP_ADD4) || (op == OP_INCA) || (op == OP_INCB);
  endfunction

  // Ops whose carry/overflow outputs are meaningful and may update C,V.
  function automatic logic is_arith_op(input logic [ALU_OPW-1:0] op);
    return ((op >= OP_SUB) && (op <= OP_RSC)) || (op == OP_CMP) || (op == OP_CMN) ||
           (op == OP_INC4) || (op == OP_ADD4) || (op == OP_INCA) || (op == OP_INCB);
  endfunction

  function automatic logic is_cmp_op(input logic [ALU_OPW-1:0] op);
    return (op >= OP_TST) && (op <= OP_CMN);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: on contention the requester that did not win
// last time is granted; last_q resets to 1 so requester 0 wins first.
module rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  logic last_q;

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
    end
  end

  // Any valid request while enabled is granted, so the grant is always taken.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= 1'b1;
    end else if (en_i && (|req_i)) begin
      last_q <= gnt_o[1];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters, sequencing
// each op IDLE -> EXEC -> RESP and owning the architectural NZCV register.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int OPW   = ALU_OPW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*OPW-1:0]   req_op,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  input  logic [1:0]         req_s,
  output logic [1:0]         rsp_valid,
  output logic [WIDTH-1:0]   rsp_result,
  output logic               rsp_err,
  output logic [3:0]         flags_q,
  output logic               busy,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [OPW-1:0]     alu_sel,
  output logic               alu_cin,
  input  logic [WIDTH-1:0]   alu_o,
  input  logic               alu_z,
  input  logic               alu_co,
  input  logic               alu_n,
  input  logic               alu_v
);

  // Handshake: a request transfers on a cycle where req_valid[i] && req_ready[i];
  // req_ready is only ever raised in IDLE and is one-hot or zero.

  state_e             state_q, state_d;
  logic               owner_q, owner_d;
  logic [OPW-1:0]     op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               s_q, s_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               err_q, err_d;
  logic [3:0]         flags_d;
  logic               idle;
  logic               accept;
  logic               gidx;

  assign idle   = (state_q == ST_IDLE);
  assign accept = |(req_valid & req_ready);
  assign gidx   = req_ready[1];

  rr_arbiter2 u_arb (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .req_i  (req_valid),
    .en_i   (idle),
    .gnt_o  (req_ready)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    res_d   = res_q;
    err_d   = err_q;
    flags_d = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          owner_d = gidx;
          op_d    = gidx ? req_op[2*OPW-1:OPW]     : req_op[OPW-1:0];
          a_d     = gidx ? req_a[2*WIDTH-1:WIDTH]  : req_a[WIDTH-1:0];
          b_d     = gidx ? req_b[2*WIDTH-1:WIDTH]  : req_b[WIDTH-1:0];
          s_d     = gidx ? req_s[1]                : req_s[0];
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_RESP;
        if (!is_legal_op(op_q)) begin
          res_d = '0;
          err_d = 1'b1;
        end else begin
          res_d = alu_o;
          err_d = 1'b0;
          // Compares always write flags; C,V only move for arithmetic ops.
          if (s_q || is_cmp_op(op_q)) begin
            flags_d[FLAG_N] = alu_n;
            flags_d[FLAG_Z] = alu_z;
            if (is_arith_op(op_q)) begin
              flags_d[FLAG_C] = alu_co;
              flags_d[FLAG_V] = alu_v;
            end
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= 1'b0;
      res_q   <= '0;
      err_q   <= 1'b0;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      res_q   <= res_d;
      err_q   <= err_d;
      flags_q <= flags_d;
    end
  end

  assign rsp_valid  = (state_q == ST_RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_result = res_q;
  assign rsp_err    = err_q;
  assign busy       = !idle;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_sel    = op_q;
  assign alu_cin    = flags_q[FLAG_C];

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU, per-request reference model and an
// expected-response queue checked by a monitor independent of the stimulus.
module tb_alu_arbiter;

  localparam int W  = 32;
  localparam int EW = 1 + 1 + W + 4 + 32;  // owner, err, result, flags, due cycle

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0]      req_valid = '0;
  logic [1:0]      req_ready;
  logic [9:0]      req_op = '0;
  logic [2*W-1:0]  req_a = '0;
  logic [2*W-1:0]  req_b = '0;
  logic [1:0]      req_s = '0;
  logic [1:0]      rsp_valid;
  logic [W-1:0]    rsp_result;
  logic            rsp_err;
  logic [3:0]      flags_q;
  logic            busy;
  logic [W-1:0]    alu_a, alu_b, alu_o;
  logic [4:0]      alu_sel;
  logic            alu_cin, alu_z, alu_co, alu_n, alu_v;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [EW-1:0] exp_q[$];
  logic [3:0]    m_flags = 4'b0000;
  logic          m_last  = 1'b1;
  int            busy_until = -10;
  logic [1:0]    acc_seen = '0;
  int            rsp_cnt = 0;
  logic [W-1:0]  last_res;
  logic [3:0]    last_flags;
  logic          last_err;
  logic [1:0]    last_owner_vec;

  alu_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_s      (req_s),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .flags_q    (flags_q),
    .busy       (busy),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_cin    (alu_cin),
    .alu_o      (alu_o),
    .alu_z      (alu_z),
    .alu_co     (alu_co),
    .alu_n      (alu_n),
    .alu_v      (alu_v)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural ALU: returns {n,z,c,v,o} ----------------
  function automatic logic [35:0] alu_f(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic cin);
    logic [32:0] s;
    logic [31:0] x, y, o;
    logic        c, ar, co, v;
    ar = 1'b1; x = a; y = b; c = 1'b0;
    case (op)
      5'd2:  begin y = ~b; c = 1'b1; end
      5'd3:  begin x = b; y = ~a; c = 1'b1; end
      5'd4:  ;
      5'd5:  c = cin;
      5'd6:  begin y = ~b; c = cin; end
      5'd7:  begin x = b; y = ~a; c = cin; end
      5'd10: begin y = ~b; c = 1'b1; end
      5'd11: ;
      5'd17: y = 32'd4;
      5'd18: begin x = b; y = 32'd4; end
      5'd30: y = 32'd4;
      5'd31: begin x = b; y = 32'd4; end
      default: ar = 1'b0;
    endcase
    s = {1'b0, x} + {1'b0, y} + {32'd0, c};
    if (ar) begin
      o = s[31:0]; co = s[32];
      v = (x[31] == y[31]) && (s[31] != x[31]);
    end else begin
      co = 1'b0; v = 1'b0;
      case (op)
        5'd0, 5'd8: o = a & b;
        5'd1, 5'd9: o = a ^ b;
        5'd12:      o = a | b;
        5'd13:      o = b;
        5'd14:      o = a & ~b;
        5'd15:      o = ~b;
        5'd16:      o = a;
        default:    o = 32'd0;
      endcase
    end
    return {o[31], (o == 32'd0), co, v, o};
  endfunction

  always_comb {alu_n, alu_z, alu_co, alu_v, alu_o} = alu_f(alu_sel, alu_a, alu_b, alu_cin);

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] model_grant(input logic [1:0] v, input logic last);
    if (v == 2'b11) return last ? 2'b01 : 2'b10;
    return v;
  endfunction

  // Reference: one request's outcome from the opcode rules, with flag state
  // advanced in accept order (ops are serialised by the block).
  function automatic logic [EW-1:0] model_op(input logic owner, input logic [4:0] op,
                                             input logic [31:0] a, input logic [31:0] b,
                                             input logic s, input int due);
    logic [35:0] r;
    logic [3:0]  f;
    logic        legal;
    f = m_flags;
    legal = (op <= 5'd18) || (op == 5'd30) || (op == 5'd31);
    if (!legal) return {owner, 1'b1, 32'd0, f, due[31:0]};
    r = alu_f(op, a, b, m_flags[1]);
    if (s || (op inside {5'd8, 5'd9, 5'd10, 5'd11})) begin
      f[3] = r[35]; f[2] = r[34];
      if (op inside {[5'd2:5'd7], 5'd10, 5'd11, 5'd17, 5'd18, 5'd30, 5'd31}) begin
        f[1] = r[33]; f[0] = r[32];
      end
    end
    m_flags = f;
    return {owner, 1'b0, r[31:0], f, due[31:0]};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [1:0]    exp_rdy;
    logic [1:0]    acc;
    logic          idle;
    logic          idx;
    logic [EW-1:0] e;
    int            due;
    if (!rst_n) begin
      check("rst_rsp_valid", {62'd0, rsp_valid}, 64'd0);
      check("rst_flags", {60'd0, flags_q}, 64'd0);
      exp_q.delete();
      m_flags = 4'b0000;
      m_last = 1'b1;
      busy_until = -10;
      acc_seen = '0;
    end else begin
      idle = (cyc > busy_until);
      exp_rdy = idle ? model_grant(req_valid, m_last) : 2'b00;
      check("req_ready", {62'd0, req_ready}, {62'd0, exp_rdy});
      check("busy", {63'd0, busy}, {63'd0, !idle});
      acc = req_valid & exp_rdy;
      if (acc != 2'b00) begin
        idx = acc[1];
        e = model_op(idx, req_op[idx*5 +: 5], req_a[idx*W +: W], req_b[idx*W +: W],
                     req_s[idx], cyc + 2);
        exp_q.push_back(e);
        m_last = idx;
        busy_until = cyc + 2;
        acc_seen[idx] = 1'b1;
      end
      if (rsp_valid != 2'b00) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_rsp: rsp_valid=%b with no outstanding request", rsp_valid);
        end else begin
          e = exp_q.pop_front();
          due = int'(e[31:0]);
          check("rsp_latency", cyc, due);
          check("rsp_owner", {62'd0, rsp_valid}, e[EW-1] ? 64'd2 : 64'd1);
          check("rsp_err", {63'd0, rsp_err}, {63'd0, e[EW-2]});
          check("rsp_result", {32'd0, rsp_result}, {32'd0, e[EW-3 -: W]});
          check("rsp_flags", {60'd0, flags_q}, {60'd0, e[35:32]});
        end
        last_res = rsp_result; last_flags = flags_q; last_err = rsp_err;
        last_owner_vec = rsp_valid;
        rsp_cnt++;
      end else if (exp_q.size() > 0 && int'(exp_q[0][31:0]) < cyc) begin
        n_tests++; n_fail++;
        $display("FAIL missing_rsp: response due at cycle %0d not seen by %0d",
                 int'(exp_q[0][31:0]), cyc);
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input int i, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic s);
    req_op[i*5 +: 5] = op;
    req_a[i*W +: W]  = a;
    req_b[i*W +: W]  = b;
    req_s[i]         = s;
    req_valid[i]     = 1'b1;
  endtask

  task automatic wait_accept(input int i);
    int k;
    for (k = 0; k < 50; k++) begin
      @(posedge clk);
      if (acc_seen[i]) break;
    end
    if (k == 50) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: requester %0d never accepted", i);
    end
    #1;
    req_valid[i] = 1'b0;
    acc_seen[i] = 1'b0;
  endtask

  task automatic wait_rsp(input int n);
    int k;
    for (k = 0; k < 50 && rsp_cnt < n; k++) @(posedge clk);
    if (rsp_cnt < n) begin
      n_tests++; n_fail++;
      $display("FAIL rsp_timeout: have %0d responses, want %0d", rsp_cnt, n);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_result", {32'd0, rsp_result}, 64'd0);
    check("rst_err", {63'd0, rsp_err}, 64'd0);
    check("rst_ready", {62'd0, req_ready}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // ADD 5+7 with flag set
    n = rsp_cnt;
    drive(0, 5'b00100, 32'd5, 32'd7, 1'b1);
    wait_accept(0);
    wait_rsp(n + 1);
    check("add_result", {32'd0, last_res}, 64'd12);
    check("add_flags", {60'd0, last_flags}, 64'd0);

    // Fresh arbiter: both valid, req0 wins then req1
    do_reset();
    n = rsp_cnt;
    drive(0, 5'b00010, 32'd3, 32'd3, 1'b1);
    drive(1, 5'b11110, 32'h100, 32'd0, 1'b0);
    wait_accept(0);
    wait_rsp(n + 1);
    check("sub_owner", {62'd0, last_owner_vec}, 64'd1);
    check("sub_flags", {60'd0, last_flags}, 64'b0110);
    wait_accept(1);
    wait_rsp(n + 2);
    check("inca_owner", {62'd0, last_owner_vec}, 64'd2);
    check("inca_result", {32'd0, last_res}, 64'h104);
    check("inca_flags", {60'd0, last_flags}, 64'b0110);

    // ADC using carry-in from previous SUB
    n = rsp_cnt;
    drive(0, 5'b00101, 32'hFFFF_FFFF, 32'd0, 1'b1);
    wait_accept(0);
    wait_rsp(n + 1);
    check("adc_result", {32'd0, last_res}, 64'd0);
    check("adc_flags", {60'd0, last_flags}, 64'b0110);

    // CMP always sets flags; MOV with s=1 keeps C,V
    n = rsp_cnt;
    drive(0, 5'b01010, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_accept(0);
    wait_rsp(n + 1);
    check("cmp_flags", {60'd0, last_flags}, 64'b1001);
    drive(0, 5'b01101, 32'd0, 32'h12, 1'b1);
    wait_accept(0);
    wait_rsp(n + 2);
    check("mov_flags", {60'd0, last_flags}, 64'b0001);

    // Illegal opcode
    n = rsp_cnt;
    drive(0, 5'b10100, 32'd9, 32'd9, 1'b1);
    wait_accept(0);
    wait_rsp(n + 1);
    check("illegal_err", {63'd0, last_err}, 64'd1);
    check("illegal_result", {32'd0, last_res}, 64'd0);
    check("illegal_flags", {60'd0, last_flags}, 64'b0001);

    // Reset during EXEC drops the op and clears flags
    n = rsp_cnt;
    drive(1, 5'b00100, 32'd1, 32'd1, 1'b1);
    wait_accept(1);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("midrst_no_rsp", rsp_cnt, n);
    check("midrst_flags", {60'd0, flags_q}, 64'd0);
    drive(0, 5'b00000, 32'hF0, 32'h3C, 1'b0);
    drive(1, 5'b00001, 32'hF0, 32'h3C, 1'b0);
    @(negedge clk);
    check("midrst_first_grant", {62'd0, req_ready}, 64'b01);
    wait_accept(0);
    wait_accept(1);

    // Randomised traffic from both requesters
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (acc_seen[i]) begin
          req_valid[i] = 1'b0;
          acc_seen[i] = 1'b0;
        end
        if (!req_valid[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            logic [31:0] ra, rb;
            ra = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            drive(i, 5'($urandom_range(0, 31)), ra, rb, 1'($urandom_range(0, 1)));
          end
        end else if ($urandom_range(0, 19) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end
    req_valid = 2'b00;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("drain_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational ALU32 between two requesters: requester 0 is the execute stage, requester 1 is the address/PC-increment path.
- Grants round-robin, sequences each operation through a fixed 3-state FSM, registers the result, and owns the architectural NZCV flag register.
- Drives the ALU operand, select and carry-in inputs, and returns a tagged response.

Parameters:
- WIDTH, 32, operand/result width.
- OPW, 5, ALU select width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  per-requester request valid, bit i = requester i
- req_ready  out  2  per-requester accept, one-hot or zero
- req_op  in  2*OPW  packed ALU select, [OPW-1:0] = req0
- req_a  in  2*WIDTH  packed operand A
- req_b  in  2*WIDTH  packed operand B
- req_s  in  2  per-requester set-flags bit
- rsp_valid  out  2  one-cycle response pulse to owning requester
- rsp_result  out  WIDTH  registered result
- rsp_err  out  1  illegal opcode flag, qualified by rsp_valid
- flags_q  out  4  architectural {N,Z,C,V}
- busy  out  1  FSM not in IDLE
- alu_a, alu_b  out  WIDTH  to ALU A, B
- alu_sel  out  OPW  to ALU sel
- alu_cin  out  1  to ALU Cin
- alu_o  in  WIDTH  ALU O
- alu_z, alu_co, alu_n, alu_v  in  1 each  ALU flags

Behaviour:
- Reset (async, rst_n=0): state=IDLE; req_ready=0; rsp_valid=0; rsp_result=0; rsp_err=0; flags_q=4'b0000; last_grant=1, so req0 wins first; operand latches=0.
- States: IDLE, EXEC, RESP.
- IDLE:
  - req_ready = one-hot grant, combinational from req_valid and last_grant.
  - Grant rule: single valid → that requester; both valid → requester != last_grant; none → 0.
  - On valid&ready: latch op/a/b/s and owner id, update last_grant, go to EXEC.
- EXEC:
  - alu_a/alu_b/alu_sel driven from latches; alu_cin = flags_q[C].
  - Capture alu_o and flags at end of cycle; go to RESP.
  - Outside EXEC, ALU inputs hold last latched values (no X).
- RESP: rsp_valid[owner]=1 for exactly one cycle with rsp_result/rsp_err; go to IDLE. rsp_result holds until the next RESP.
- Latency: accept at cycle T, response at T+2. Peak throughput one op per 3 cycles. req_ready=0 in EXEC/RESP.
- Requester rule: req_valid must hold with stable payload until accepted. Dropping valid before accept is legal; the request is simply not taken.
- Legal opcodes: 00000–10010, 11110, 11111. Any other → rsp_err=1, rsp_result=0, flags_q unchanged.
- Flag update at end of EXEC, applied when req_s=1 OR op ∈ {01000,01001,01010,01011} (TST/TEQ/CMP/CMN always set flags):
  - N,Z always take alu_n, alu_z.
  - C,V take alu_co, alu_v only for arithmetic ops {00010–00111, 01010, 01011, 10001, 10010, 11110, 11111}; otherwise preserved.
- Result write: rsp_result is not suppressed for compare ops; it carries alu_o and the requester ignores it.
- Simultaneous events: a new req_valid during EXEC/RESP waits; no grant until IDLE. Fairness is maintained by last_grant.
- Reset mid-operation: in-flight op dropped, no rsp_valid, flags cleared.
- Wrap-around: none; ALU arithmetic is modulo 2^WIDTH, carry via alu_co.

Decomposition:
- Shared package alu_pkg:
  - ALU select constants (AND, EOR, SUB, RSB, ADD, ADC, SBC, RSC, TST, TEQ, CMP, CMN, ORR, MOV, BIC, MVN, PASSA, INC4, ADD4, INCA, INCB).
  - Flag-bit index constants N=3, Z=2, C=1, V=0.
  - State enum.
  - Functions is_legal_op, is_arith_op, is_cmp_op.
- One sub-module: rr_arbiter2 (2-way round-robin grant with last_grant register).
- The ALU is instantiated outside this block.

Test Plan:
- Reset, then req0 ADD (00100) a=5, b=7, s=1 → rsp_valid[0] at T+2; result 12; flags_q=0000.
- Both valid together, req0 SUB 3-3, req1 INCA a=0x100 → req0 granted first, flags Z=1 C=1; req1 then granted, result 0x104, flags unchanged (s=0).
- Flags C=1 from previous op; ADC (00101) a=0xFFFFFFFF, b=0, s=1 → result 0, flags N0 Z1 C1 V0.
- CMP (01010) a=0x7FFFFFFF, b=0xFFFFFFFF with s=0 → flags updated N1 Z0 C0 V1; next MOV with s=1 → C,V preserved.
- Illegal op 10100 → rsp_err=1, result 0, flags_q unchanged.
- Assert rst_n=0 during EXEC → no rsp_valid, flags_q=0000, req_ready for req0 in first IDLE after release.
